// File: rtl/debounced_multi_shot.sv
// debounced_multi_shot
//   Multi-channel key conditioner. Each channel polarity-normalises a raw
//   button input, passes it through a 2-flop synchroniser, debounces it and
//   emits a fixed-width pulse per press, with optional auto-repeat while held.
//   Channels are fully independent.
//
// Ports
//   clk     in  1         system clock
//   rst     in  1         asynchronous reset, active low
//   raw_in  in  CHANNELS  asynchronous button inputs (polarity per ACTIVE_LOW)
//   rep_en  in  CHANNELS  per-channel auto-repeat enable (synchronous)
//   q       out CHANNELS  per-channel pulse output, active high
//   held    out CHANNELS  per-channel debounced level, 1 = asserted
module debounced_multi_shot #(
  parameter int CHANNELS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int PULSE_CYCLES    = 1,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 12500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [CHANNELS-1:0] rep_en,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] held
);

  if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || PULSE_CYCLES < 1 ||
      REPEAT_DELAY <= PULSE_CYCLES || REPEAT_PERIOD <= PULSE_CYCLES) begin : g_param_error
    $error("debounced_multi_shot: illegal parameter combination");
  end

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int PH_W    = $clog2(REP_MAX + 1);

  localparam logic            INVERT      = (ACTIVE_LOW != 0);
  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_SAT      = PH_W'(REP_MAX);
  localparam logic [PH_W-1:0] PULSE_LAST  = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0] DELAY_LAST  = PH_W'(REPEAT_DELAY - 1);
  localparam logic [PH_W-1:0] PERIOD_LAST = PH_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE     = 2'd1,
    HOLD_WAIT = 2'd2,
    REPEAT    = 2'd3
  } state_t;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic            raw_norm;
    logic            sync1, sync2;
    logic            held_r;
    logic [DB_W-1:0] db_cnt;
    state_t          state, state_nx;
    logic [PH_W-1:0] phase, phase_nx;
    // Selects REPEAT_DELAY (first repeat after a press) or REPEAT_PERIOD.
    logic            first, first_nx;

    assign raw_norm = raw_in[c] ^ INVERT;

    // Synchroniser and debouncer. The counter only runs while the
    // synchronised level disagrees with held, so it never exceeds DB_LAST.
    always_ff @(posedge clk or negedge rst) begin
      // NOTE: every sequential block resets asynchronously and uses only
      // non-blocking assignments so all flops update from pre-edge values.
      if (!rst) begin
        sync1  <= 1'b0;
        sync2  <= 1'b0;
        held_r <= 1'b0;
        db_cnt <= '0;
      end else begin
        sync1 <= raw_norm;
        sync2 <= sync1;
        if (sync2 == held_r) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          held_r <= ~held_r;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= IDLE;
        phase <= '0;
        first <= 1'b0;
      end else begin
        state <= state_nx;
        phase <= phase_nx;
        first <= first_nx;
      end
    end

    // Phase counts edges since the current pulse start (or since repeat was
    // re-enabled); it saturates rather than wrapping.
    always_comb begin
      // NOTE: defaults first, so every path assigns every output and no
      // latch is inferred.
      state_nx = state;
      first_nx = first;
      phase_nx = (phase == PH_SAT) ? phase : phase + PH_W'(1);
      unique case (state)
        IDLE: begin
          if (held_r) begin
            state_nx = PULSE;
            phase_nx = '0;
            first_nx = 1'b1;
          end
        end
        PULSE: begin
          // Pulses always run to completion, whatever held does meanwhile.
          if (phase == PULSE_LAST) begin
            if (!held_r)        state_nx = IDLE;
            else if (rep_en[c]) state_nx = REPEAT;
            else                state_nx = HOLD_WAIT;
          end
        end
        REPEAT: begin
          if (!held_r) begin
            state_nx = IDLE;
          end else if (!rep_en[c]) begin
            state_nx = HOLD_WAIT;
          end else if (phase == (first ? DELAY_LAST : PERIOD_LAST)) begin
            state_nx = PULSE;
            phase_nx = '0;
            first_nx = 1'b0;
          end
        end
        HOLD_WAIT: begin
          // Re-enabling repeat here restarts the phase with the short period.
          first_nx = 1'b0;
          if (!held_r) begin
            state_nx = IDLE;
          end else if (rep_en[c]) begin
            state_nx = REPEAT;
            phase_nx = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    // Decoded straight from the state register so reset clears q at once.
    assign q[c]    = (state == PULSE);
    assign held[c] = held_r;
  end

endmodule

// File: tb/tb_debounced_multi_shot.sv
// tb_debounced_multi_shot
//   Directed scenarios followed by a randomised phase. Every cycle the DUT's
//   q and held are compared with a time-stamp based reference model.
module tb_debounced_multi_shot;
  localparam int CH = 2;
  localparam int DB = 4;
  localparam int PC = 2;
  localparam int RD = 10;
  localparam int RP = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] raw_in;
  logic [CH-1:0] rep_en;
  logic [CH-1:0] q;
  logic [CH-1:0] held;

  int checks = 0;
  int errors = 0;

  debounced_multi_shot #(
    .CHANNELS(CH), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB),
    .PULSE_CYCLES(PC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .rep_en(rep_en),
    .q(q), .held(held)
  );

  always #5 clk = ~clk;

  // Reference model: synchroniser as a 2-deep delay line, debounce as a
  // run-length of disagreeing samples, pulses as start time stamps.
  int n = 0;
  bit m_s1[CH], m_s2[CH], m_held[CH];
  int m_run[CH];
  bit m_busy[CH];      // a press session is active (press accepted, not yet released)
  bit m_paused[CH];    // session waiting for rep_en
  int m_last[CH];      // edge index of the most recent pulse start
  int m_next[CH];      // edge index of the next scheduled repeat start

  // Observation trackers for the directed scenarios.
  int            t_cyc;
  int            q_high[CH], q_rises[CH], held_at[CH];
  int            rise_at[CH][8];
  logic [CH-1:0] q_prev = '0;

  task automatic check(string tag, int act, int exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_held[c] = 0; m_run[c] = 0;
      m_busy[c] = 0; m_paused[c] = 0; m_last[c] = -1000; m_next[c] = 0;
    end
  endtask

  function automatic logic [CH-1:0] exp_q();
    logic [CH-1:0] r = '0;
    for (int c = 0; c < CH; c++) r[c] = m_busy[c] && (n - m_last[c] < PC);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_held();
    logic [CH-1:0] r = '0;
    for (int c = 0; c < CH; c++) r[c] = m_held[c];
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs applied now.
  task automatic model_edge();
    n++;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < CH; c++) begin
      bit h = m_held[c];
      bit r = rep_en[c];
      if (!m_busy[c]) begin
        if (h) begin
          m_busy[c] = 1; m_paused[c] = 0; m_last[c] = n; m_next[c] = n + RD;
        end
      end else if (n - m_last[c] >= PC) begin
        if (!h)              m_busy[c] = 0;
        else if (!r)         m_paused[c] = 1;
        else if (m_paused[c]) begin
          m_paused[c] = 0; m_next[c] = n + RP;
        end else if (n == m_next[c]) begin
          m_last[c] = n; m_next[c] = n + RP;
        end
      end
      if (m_s2[c] == m_held[c]) m_run[c] = 0;
      else                      m_run[c] = m_run[c] + 1;
      if (m_run[c] == DB) begin
        m_held[c] = m_s2[c];
        m_run[c]  = 0;
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = !raw_in[c];
    end
  endtask

  task automatic track_clear();
    t_cyc = 0;
    for (int c = 0; c < CH; c++) begin
      q_high[c] = 0; q_rises[c] = 0; held_at[c] = -1;
      for (int k = 0; k < 8; k++) rise_at[c][k] = -1;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    t_cyc++;
    check("q", int'(q), int'(exp_q()));
    check("held", int'(held), int'(exp_held()));
    for (int c = 0; c < CH; c++) begin
      if (q[c]) q_high[c]++;
      if (q[c] && !q_prev[c]) begin
        if (q_rises[c] < 8) rise_at[c][q_rises[c]] = t_cyc;
        q_rises[c]++;
      end
      if (held[c] && held_at[c] < 0) held_at[c] = t_cyc;
    end
    q_prev = q;
  endtask

  task automatic run(int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; raw_in = '1; rep_en = '0;
    model_reset();
    track_clear();
    #1 rst = 1'b0;
    run(3);
    rst = 1'b1;
    run(4);
    check("reset_q", int'(q), 0);
    check("reset_held", int'(held), 0);

    // 1: single press, no repeat.
    track_clear();
    raw_in[0] = 1'b0;
    run(20);
    check("t1_held_latency", held_at[0], 6);
    check("t1_pulse_start", rise_at[0][0], 7);
    check("t1_pulse_count", q_rises[0], 1);
    check("t1_pulse_width", q_high[0], 2);
    raw_in[0] = 1'b1;
    run(12);

    // 2: bounce shorter than the debounce window.
    track_clear();
    for (int i = 0; i < 10; i++) begin
      raw_in[0] = ~raw_in[0];
      run(3);
    end
    check("t2_held", held_at[0], -1);
    check("t2_pulses", q_rises[0], 0);
    run(8);

    // 3: auto-repeat on channel 1.
    rep_en[1] = 1'b1;
    track_clear();
    raw_in[1] = 1'b0;
    run(40);
    check("t3_start0", rise_at[1][0], 7);
    check("t3_start1", rise_at[1][1], 17);
    check("t3_start2", rise_at[1][2], 22);
    check("t3_start3", rise_at[1][3], 27);
    check("t3_count", q_rises[1], 6);
    check("t3_width", q_high[1], 12);
    raw_in[1] = 1'b1;
    track_clear();
    run(15);
    check("t3_after_release", q_rises[1], 1);
    rep_en[1] = 1'b0;
    run(4);

    // 4: simultaneous press on both channels.
    track_clear();
    raw_in = 2'b00;
    run(20);
    check("t4_ch0_start", rise_at[0][0], 7);
    check("t4_ch1_start", rise_at[1][0], 7);
    check("t4_ch0_count", q_rises[0], 1);
    check("t4_ch1_count", q_rises[1], 1);
    raw_in = 2'b11;
    run(12);

    // 5: release mid-pulse, re-press before the release is accepted.
    track_clear();
    raw_in[0] = 1'b0;
    run(7);
    raw_in[0] = 1'b1;
    run(3);
    raw_in[0] = 1'b0;
    run(20);
    check("t5_width", q_high[0], 2);
    check("t5_count", q_rises[0], 1);
    check("t5_still_held", int'(held[0]), 1);
    raw_in[0] = 1'b1;
    run(12);

    // 6: asynchronous reset mid-pulse, key kept pressed.
    track_clear();
    raw_in[0] = 1'b0;
    run(7);
    check("t6_pulse_before_rst", int'(q[0]), 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("t6_async_q", int'(q), 0);
    check("t6_async_held", int'(held), 0);
    run(2);
    rst = 1'b1;
    track_clear();
    run(15);
    check("t6_fresh_start", rise_at[0][0], 7);
    check("t6_fresh_count", q_rises[0], 1);
    raw_in[0] = 1'b1;
    run(12);

    // Randomised phase: random levels, hold times and repeat enables.
    for (int seg = 0; seg < 70; seg++) begin
      raw_in = 2'($urandom_range(0, 3));
      rep_en = 2'($urandom_range(0, 3));
      run(int'($urandom_range(1, 16)));
    end
    raw_in = '1;
    run(15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
